// File: rtl/tdm_demux.sv
// tdm_demux: recovers WIDTH channels from a time-division 1-bit link into a
// parallel word, flags each completed frame and reports framing errors.
module tdm_demux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             frame_err
);

    localparam int unsigned     CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shd;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               r_frame_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_shd_nxt;
    logic [WIDTH-1:0]   w_out_data_nxt;
    logic               w_out_valid_nxt;
    logic               w_frame_err_nxt;

    // State register; reset wins over a simultaneous beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, slot capture and output pulses; idle cycles only clear pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shd_nxt       = r_shd;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    if (in_sof) begin
                        w_shd_nxt[0] = in_bit;
                        w_cnt_nxt    = CNT_W'(1);
                        w_state_nxt  = RECV;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end
                RECV: begin
                    if (in_sof) begin
                        // Early SOF: drop the partial frame and restart at slot 0.
                        w_frame_err_nxt = 1'b1;
                        w_shd_nxt[0]    = in_bit;
                        w_cnt_nxt       = CNT_W'(1);
                    end else if (r_cnt == LAST) begin
                        w_out_data_nxt  = {in_bit, r_shd[WIDTH-2:0]};
                        w_out_valid_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_shd_nxt[r_cnt] = in_bit;
                        w_cnt_nxt        = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_shd       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_shd       <= w_shd_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: directed scenarios plus randomized traffic checked
// against a queue-based frame model.
module tb_tdm_demux;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         in_bit;
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         frame_err;

    tdm_demux #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: bits of the open frame, or no frame at all.
    logic         m_open;
    logic         m_q[$];
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_err;

    int n_tests;
    int n_fail;
    int cyc;
    int n_vseen;
    int n_eseen;
    int vtimes[$];

    // Apply one cycle of stimulus to the model as seen at the sampling edge.
    task automatic model(input logic r, input logic v, input logic b, input logic s);
        logic [W-1:0] word;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (r) begin
            m_open   = 1'b0;
            m_q      = {};
            exp_data = '0;
        end else if (v) begin
            if (s) begin
                exp_err = m_open;
                m_open  = 1'b1;
                m_q     = {};
                m_q.push_back(b);
            end else if (!m_open) begin
                exp_err = 1'b1;
            end else begin
                m_q.push_back(b);
                if (m_q.size() == W) begin
                    word = '0;
                    for (int i = 0; i < int'(W); i++) word[i] = m_q[i];
                    exp_data  = word;
                    exp_valid = 1'b1;
                    m_open    = 1'b0;
                    m_q       = {};
                end
            end
        end
    endtask

    task automatic check(input string tag);
        n_tests++;
        assert (out_data === exp_data) else begin
            n_fail++;
            $error("FAIL %s out_data got %h expected %h (cycle %0d)", tag, out_data, exp_data, cyc);
        end
        n_tests++;
        assert (out_valid === exp_valid) else begin
            n_fail++;
            $error("FAIL %s out_valid got %b expected %b (cycle %0d)", tag, out_valid, exp_valid, cyc);
        end
        n_tests++;
        assert (frame_err === exp_err) else begin
            n_fail++;
            $error("FAIL %s frame_err got %b expected %b (cycle %0d)", tag, frame_err, exp_err, cyc);
        end
        n_tests++;
        assert (!(out_valid === 1'b1 && frame_err === 1'b1)) else begin
            n_fail++;
            $error("FAIL %s out_valid and frame_err both high (cycle %0d)", tag, cyc);
        end
        if (out_valid === 1'b1) begin
            n_vseen++;
            vtimes.push_back(cyc);
        end
        if (frame_err === 1'b1) n_eseen++;
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic b, input logic s);
        reset    = r;
        in_valid = v;
        in_bit   = b;
        in_sof   = s;
        @(posedge clk);
        model(r, v, b, s);
        cyc++;
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    // Send a full frame; optional gap of gap_len idle cycles after slot gap_slot.
    task automatic send_frame(input string tag, input logic [W-1:0] f,
                              input int gap_slot, input int gap_len);
        for (int i = 0; i < int'(W); i++) begin
            step(tag, 1'b0, 1'b1, f[i], i == 0);
            if (i == gap_slot) idle(tag, gap_len);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] want);
        n_tests++;
        assert (out_data === want) else begin
            n_fail++;
            $error("FAIL %s out_data got %h expected %h", tag, out_data, want);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; n_vseen = 0; n_eseen = 0;
        m_open = 1'b0; exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;

        // Reset with random inputs, then quiet link.
        step("rst", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        step("rst", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        idle("rst_idle", 5);
        expect_word("rst_data", 8'h00);
        expect_int("rst_pulses", n_vseen + n_eseen, 0);

        // Clean frame: slot bits 1,0,1,1,0,0,1,0.
        n_vseen = 0; n_eseen = 0;
        send_frame("clean", 8'h4D, -1, 0);
        expect_word("clean_data", 8'h4D);
        idle("clean", 2);
        expect_int("clean_vcount", n_vseen, 1);
        expect_int("clean_ecount", n_eseen, 0);

        // Gapped frame then an all-ones frame back to back.
        n_vseen = 0; n_eseen = 0; vtimes = {};
        send_frame("gap", 8'h4D, 3, 3);
        expect_word("gap_data", 8'h4D);
        send_frame("b2b", 8'hFF, -1, 0);
        expect_word("b2b_data", 8'hFF);
        idle("b2b", 2);
        expect_int("b2b_vcount", n_vseen, 2);
        expect_int("b2b_spacing", (vtimes.size() == 2) ? vtimes[1] - vtimes[0] : -1, 8);
        expect_int("b2b_ecount", n_eseen, 0);

        // Early SOF: partial frame of 5 beats, then 8'hAA.
        n_vseen = 0; n_eseen = 0;
        step("esof", 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step("esof", 1'b0, 1'b1, 1'($urandom), 1'b0);
        send_frame("esof", 8'hAA, -1, 0);
        expect_word("esof_data", 8'hAA);
        idle("esof", 2);
        expect_int("esof_ecount", n_eseen, 1);
        expect_int("esof_vcount", n_vseen, 1);

        // Orphan data while idle, then a valid frame.
        n_vseen = 0; n_eseen = 0;
        step("orph", 1'b0, 1'b1, 1'b1, 1'b0);
        step("orph", 1'b0, 1'b1, 1'b0, 1'b0);
        expect_word("orph_hold", 8'hAA);
        send_frame("orph", 8'h3C, -1, 0);
        expect_word("orph_data", 8'h3C);
        expect_int("orph_ecount", n_eseen, 2);

        // Reset after slot 5, then frame 8'h81.
        n_vseen = 0; n_eseen = 0;
        for (int i = 0; i < 6; i++) step("rmid", 1'b0, 1'b1, 1'($urandom), i == 0);
        step("rmid", 1'b1, 1'b1, 1'b1, 1'b0);
        expect_word("rmid_clear", 8'h00);
        send_frame("rmid", 8'h81, -1, 0);
        expect_word("rmid_data", 8'h81);
        idle("rmid", 1);
        expect_int("rmid_ecount", n_eseen, 0);
        expect_int("rmid_vcount", n_vseen, 1);

        // Randomized traffic: whole frames with gaps mixed with noise and resets.
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 3))
                0, 1: send_frame("rnd_frame", W'($urandom), $urandom_range(0, W),
                                 $urandom_range(0, 3));
                2: for (int j = 0; j < 4; j++)
                       step("rnd_noise", 1'b0, ($urandom_range(0, 3) != 0),
                            1'($urandom), ($urandom_range(0, 5) == 0));
                default: step("rnd_rst", ($urandom_range(0, 7) == 0), 1'($urandom),
                              1'($urandom), 1'($urandom));
            endcase
        end
        idle("tail", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive end of the team's time-division 1-bit link. Upstream, a mux walks its select through WIDTH slots and places one channel's bit on the wire per valid cycle. This block recovers the WIDTH channels into a parallel register and flags each completed frame. It also detects framing errors: a frame start arriving early, or data arriving with no frame open.

## Interface
- WIDTH, 8, number of slots (channels) per frame; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- in_bit  input  1  serial data bit for the current slot.
- in_valid  input  1  in_bit/in_sof are meaningful this cycle; low = idle gap.
- in_sof  input  1  start of frame; marks slot 0, meaningful only with in_valid.
- out_data  output  WIDTH  last complete frame; bit k = slot k (slot 0 = LSB).
- out_valid  output  1  one-cycle pulse: out_data was just updated.
- frame_err  output  1  one-cycle pulse: framing violation on the previous valid beat.

## Operation
- State: IDLE (no frame open) / RECV (frame open); slot counter cnt, width ceil(log2 WIDTH), range 0..WIDTH-1; shadow register shd[WIDTH-1:0].
- Beat = rising edge with in_valid=1. Cycles with in_valid=0 change nothing; gaps of any length are allowed mid-frame. out_valid and frame_err drop to 0.
- IDLE, beat with in_sof=1: shd[0]<=in_bit, cnt<=1, go to RECV.
- IDLE, beat with in_sof=0: discard the bit, pulse frame_err, stay in IDLE.
- RECV, beat with in_sof=0, cnt<WIDTH-1: shd[cnt]<=in_bit, cnt<=cnt+1.
- RECV, beat with in_sof=0, cnt==WIDTH-1 (last slot):
  - out_data<={in_bit, shd[WIDTH-2:0]}.
  - Pulse out_valid.
  - cnt<=0, go to IDLE.
- RECV, beat with in_sof=1 (early SOF):
  - Pulse frame_err.
  - Abandon the partial frame: out_data is not updated and out_valid stays low.
  - Restart: shd[0]<=in_bit, cnt<=1, stay in RECV.
- Back-to-back frames: the SOF beat immediately after a last-slot beat is the normal IDLE+SOF case. No frame_err and no dead cycle.
- out_data holds its value between frames and after errors. Unwritten shd bits are don't-care and never reach out_data.
- Reset:
  - State=IDLE, cnt=0, shd=0, out_data=0, out_valid=0, frame_err=0.
  - Reset wins over a simultaneous beat; that beat is lost.
  - Reset mid-frame discards the partial frame without a frame_err pulse.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- out_data/out_valid: the edge sampling the last-slot beat updates them. They are visible for the following cycle, so latency is 1 clk from the last beat's sample edge.
- out_valid is high for exactly 1 cycle per completed frame. The minimum spacing between pulses is WIDTH cycles (back-to-back frames with no gaps).
- frame_err is high for exactly 1 cycle after the offending beat's edge. Consecutive bad beats give consecutive pulses, with frame_err high continuously.
- out_valid and frame_err are never high in the same cycle. Both are 0 in the cycle after reset is sampled high.

## Test plan
- Reset/idle:
  - Stimulus: hold reset 2 cycles with random in_*, then release with in_valid=0 for 5 cycles.
  - Response: out_data=8'h00, out_valid=0 and frame_err=0 throughout.
- Clean frame, WIDTH=8:
  - Stimulus: beats of slot bits 1,0,1,1,0,0,1,0 (SOF on the first), no gaps.
  - Response: out_data=8'h4D and out_valid=1 in the cycle after beat 8 only; frame_err stays 0.
- Gapped frame plus back-to-back:
  - Stimulus: the same frame with 3 idle cycles after slot 3, then immediately a second frame of all ones.
  - Response: 8'h4D with a single out_valid pulse, then 8'hFF with a second out_valid pulse exactly 8 cycles later.
- Early SOF:
  - Stimulus: SOF plus 4 beats, then SOF and a full 8-beat frame of bits 0,1,0,1,0,1,0,1.
  - Response: frame_err pulses once, after the second SOF. No out_valid for the partial frame. Then out_data=8'hAA with one out_valid.
- Orphan data:
  - Stimulus: 2 beats with in_sof=0 while IDLE, then a valid frame.
  - Response: frame_err high for 2 consecutive cycles, out_data unchanged until the valid frame completes.
- Reset mid-frame:
  - Stimulus: assert reset after slot 5 of a frame, then send a full frame 8'h81.
  - Response: outputs cleared, no error pulse; out_data=8'h81 with one out_valid pulse.
